// File: rtl/trig_ctrl_gen_pkg.sv
// trig_pkg: shared codes for the oscilloscope trigger controller.
//   mode codes  : MODE_NORM, MODE_AUTO, MODE_SINGLE (code 3 behaves as normal)
//   slope codes : SLOPE_FALL, SLOPE_RISE, SLOPE_BOTH (code 3 behaves as rising)
//   state_t     : trigger FSM encoding
package trig_pkg;

  localparam logic [1:0] MODE_NORM   = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam logic [1:0] SLOPE_FALL  = 2'd0;
  localparam logic [1:0] SLOPE_RISE  = 2'd1;
  localparam logic [1:0] SLOPE_BOTH  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/trig_ctrl_gen_if.sv
// trig_ctrl_gen_if: front-end / capture-side bundle of the trigger controller.
//   master : sampler + capture controller side (drives samples, settings, arm, rst_trig)
//   slave  : trigger controller (returns trigger, trig_pulse, trig_auto, trig_ch, armed)
interface trig_ctrl_gen_if #(
  parameter int DW  = 8,
  parameter int NCH = 2,
  parameter int CW  = 1,
  parameter int HW  = 16
);

  logic [NCH*DW-1:0] sample;
  logic              sample_valid;
  logic [CW-1:0]     ch_sel;
  logic [DW-1:0]     level;
  logic [DW-1:0]     hyst;
  logic [1:0]        slope;
  logic [1:0]        mode;
  logic [HW-1:0]     holdoff;
  logic              arm;
  logic              rst_trig;
  logic              trigger;
  logic              trig_pulse;
  logic              trig_auto;
  logic [CW-1:0]     trig_ch;
  logic              armed;

  modport master (
    output sample, sample_valid, ch_sel, level, hyst, slope, mode, holdoff, arm, rst_trig,
    input  trigger, trig_pulse, trig_auto, trig_ch, armed
  );

  modport slave (
    input  sample, sample_valid, ch_sel, level, hyst, slope, mode, holdoff, arm, rst_trig,
    output trigger, trig_pulse, trig_auto, trig_ch, armed
  );

endinterface

// File: rtl/trig_ctrl_gen_edge_det.sv
// trig_edge_det: hysteresis level-crossing detector for one sample stream.
//   clk, rst  : clock, async active-high reset
//   valid     : sample qualifier; flags and history only move on valid cycles
//   clear     : source changed; forget flags and history (the current sample,
//               if valid, becomes the first history sample of the new source)
//   s         : current sample
//   level     : trigger level
//   hyst      : hysteresis half-band
//   rise_hit  : valid rising crossing this cycle (combinational)
//   fall_hit  : valid falling crossing this cycle (combinational)
module trig_edge_det #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          clear,
  input  logic [DW-1:0] s,
  input  logic [DW-1:0] level,
  input  logic [DW-1:0] hyst,
  output logic          rise_hit,
  output logic          fall_hit
);

  logic [DW:0]   hi_sum_s;
  logic [DW-1:0] lo_th_s;
  logic [DW-1:0] hi_th_s;
  logic          below_r;
  logic          above_r;
  logic [1:0]    hist_r;
  logic          below_eff_s;
  logic          above_eff_s;
  logic [1:0]    hist_eff_s;
  logic          hist_ok_s;

  // Saturating thresholds around the level.
  always_comb begin
    hi_sum_s = {1'b0, level} + {1'b0, hyst};
    if (hyst > level) begin
      lo_th_s = {DW{1'b0}};
    end else begin
      lo_th_s = level - hyst;
    end
    if (hi_sum_s[DW]) begin
      hi_th_s = {DW{1'b1}};
    end else begin
      hi_th_s = hi_sum_s[DW-1:0];
    end
  end

  // Effective state: a source change wipes history before this sample is judged.
  always_comb begin
    if (clear) begin
      below_eff_s = 1'b0;
      above_eff_s = 1'b0;
      hist_eff_s  = 2'd0;
    end else begin
      below_eff_s = below_r;
      above_eff_s = above_r;
      hist_eff_s  = hist_r;
    end
    // The current sample is the second one when one earlier sample is on record.
    hist_ok_s = (hist_eff_s != 2'd0);
    rise_hit  = valid && hist_ok_s && below_eff_s && (s >= level);
    fall_hit  = valid && hist_ok_s && above_eff_s && (s <= level);
  end

  // Hysteresis flags and saturating history count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      below_r <= 1'b0;
      above_r <= 1'b0;
      hist_r  <= 2'd0;
    end else if (valid) begin
      below_r <= (s < lo_th_s) ? 1'b1 : (rise_hit ? 1'b0 : below_eff_s);
      above_r <= (s > hi_th_s) ? 1'b1 : (fall_hit ? 1'b0 : above_eff_s);
      hist_r  <= (hist_eff_s == 2'd2) ? 2'd2 : (hist_eff_s + 2'd1);
    end else begin
      below_r <= below_eff_s;
      above_r <= above_eff_s;
      hist_r  <= hist_eff_s;
    end
  end

endmodule

// File: rtl/trig_ctrl_gen.sv
// trig_ctrl_gen: oscilloscope trigger controller (channel mux, edge detection,
// normal/auto/single FSM, auto timeout and post-acknowledge holdoff).
//   clk, rst : clock, async active-high reset
//   bus      : trig_ctrl_gen_if.slave
//              in : sample, sample_valid, ch_sel, level, hyst, slope, mode,
//                   holdoff, arm, rst_trig
//              out: trigger (sticky), trig_pulse (event strobe), trig_auto
//                   (timeout trigger), trig_ch (latched channel), armed
module trig_ctrl_gen
  import trig_pkg::*;
#(
  parameter int DW       = 8,
  parameter int NCH      = 2,
  parameter int CW       = 1,
  parameter int AUTO_TOP = 15,
  parameter int AW       = 20,
  parameter int HW       = 16
) (
  input  logic             clk,
  input  logic             rst,
  trig_ctrl_gen_if.slave   bus
);

  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TOP - 1);
  localparam logic [AW-1:0] AUTO_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0] HOLD_ONE  = {{(HW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] ch_prev_r;
  logic          ch_clear_s;
  logic [DW-1:0] sample_sel_s;
  logic          rise_hit_s;
  logic          fall_hit_s;
  logic          hit_s;
  logic          timeout_s;
  logic          fire_s;
  logic          fire_auto_s;
  logic          ack_s;
  logic [AW-1:0] auto_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic [HW-1:0] hold_inc_s;
  logic          trigger_r;
  logic          trig_pulse_r;
  logic          trig_auto_r;
  logic [CW-1:0] trig_ch_r;
  logic          armed_r;

  // Channel mux; codes without a channel fall back to channel 0.
  always_comb begin
    sample_sel_s = bus.sample[DW-1:0];
    for (int k = 1; k < NCH; k++) begin
      if (bus.ch_sel == CW'(k)) begin
        sample_sel_s = bus.sample[k*DW +: DW];
      end else begin
        sample_sel_s = sample_sel_s;
      end
    end
  end

  // Remember the last selection so a change can flush the detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_prev_r <= {CW{1'b0}};
    end else begin
      ch_prev_r <= bus.ch_sel;
    end
  end

  assign ch_clear_s = (bus.ch_sel != ch_prev_r);

  trig_edge_det #(.DW(DW)) u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .valid    (bus.sample_valid),
    .clear    (ch_clear_s),
    .s        (sample_sel_s),
    .level    (bus.level),
    .hyst     (bus.hyst),
    .rise_hit (rise_hit_s),
    .fall_hit (fall_hit_s)
  );

  // Slope qualification, auto timeout and holdoff increment.
  always_comb begin
    case (bus.slope)
      SLOPE_FALL: hit_s = fall_hit_s;
      SLOPE_RISE: hit_s = rise_hit_s;
      SLOPE_BOTH: hit_s = rise_hit_s | fall_hit_s;
      default:    hit_s = rise_hit_s;
    endcase
    timeout_s  = bus.sample_valid && (bus.mode == MODE_AUTO) && (auto_cnt_r == AUTO_LAST);
    hold_inc_s = hold_cnt_r + HOLD_ONE;
  end

  // FSM next state and trigger/acknowledge events.
  always_comb begin
    state_next_s = state_r;
    fire_s       = 1'b0;
    fire_auto_s  = 1'b0;
    ack_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.arm) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (hit_s || timeout_s) begin
          state_next_s = ST_TRIG;
          fire_s       = 1'b1;
          // A real crossing wins over a coincident timeout.
          fire_auto_s  = timeout_s && !hit_s;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_TRIG: begin
        if (bus.rst_trig) begin
          ack_s = 1'b1;
          if (bus.mode == MODE_SINGLE) begin
            state_next_s = ST_IDLE;
          end else if (bus.holdoff == {HW{1'b0}}) begin
            state_next_s = ST_ARMED;
          end else begin
            state_next_s = ST_HOLD;
          end
        end else begin
          state_next_s = ST_TRIG;
        end
      end
      ST_HOLD: begin
        // >= rather than == so a holdoff lowered mid-count cannot strand us here.
        if (bus.sample_valid && (hold_inc_s >= bus.holdoff)) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Auto counter: valid samples in ARMED since entry or last hit; parks at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt_r <= {AW{1'b0}};
    end else if ((state_r != ST_ARMED) || hit_s) begin
      auto_cnt_r <= {AW{1'b0}};
    end else if (bus.sample_valid && (auto_cnt_r != AUTO_LAST)) begin
      auto_cnt_r <= auto_cnt_r + AUTO_ONE;
    end else begin
      auto_cnt_r <= auto_cnt_r;
    end
  end

  // Holdoff counter: valid samples since entering HOLDOFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= {HW{1'b0}};
    end else if (state_r != ST_HOLD) begin
      hold_cnt_r <= {HW{1'b0}};
    end else if (bus.sample_valid) begin
      hold_cnt_r <= hold_inc_s;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigger_r    <= 1'b0;
      trig_pulse_r <= 1'b0;
      trig_auto_r  <= 1'b0;
      trig_ch_r    <= {CW{1'b0}};
      armed_r      <= 1'b0;
    end else begin
      trig_pulse_r <= fire_s;
      armed_r      <= (state_next_s == ST_ARMED);
      if (fire_s) begin
        trigger_r   <= 1'b1;
        trig_auto_r <= fire_auto_s;
        trig_ch_r   <= bus.ch_sel;
      end else if (ack_s) begin
        trigger_r   <= 1'b0;
        trig_auto_r <= 1'b0;
        trig_ch_r   <= trig_ch_r;
      end else begin
        trigger_r   <= trigger_r;
        trig_auto_r <= trig_auto_r;
        trig_ch_r   <= trig_ch_r;
      end
    end
  end

  assign bus.trigger    = trigger_r;
  assign bus.trig_pulse = trig_pulse_r;
  assign bus.trig_auto  = trig_auto_r;
  assign bus.trig_ch    = trig_ch_r;
  assign bus.armed      = armed_r;

endmodule

// File: tb/tb_trig_ctrl_gen.sv
// Directed bench for trig_ctrl_gen. Status vector st = {trigger, trig_pulse,
// trig_auto, armed}; every expected value is hand-derived from the scenario.
module tb_trig_ctrl_gen;

  logic       clk;
  logic       rst;
  int         tests_run;
  int         tests_failed;
  logic [3:0] st;

  trig_ctrl_gen_if #(.DW(8), .NCH(2), .CW(1), .HW(16)) bus ();

  trig_ctrl_gen #(
    .DW(8), .NCH(2), .CW(1), .AUTO_TOP(15), .AW(20), .HW(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign st = {bus.trigger, bus.trig_pulse, bus.trig_auto, bus.armed};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: apply inputs, take the edge, settle, drop the pulses.
  task automatic tick(input logic v, input logic [7:0] s0, input logic [7:0] s1,
                      input logic a, input logic rt);
    bus.sample_valid = v;
    bus.sample       = {s1, s0};
    bus.arm          = a;
    bus.rst_trig     = rt;
    @(posedge clk);
    #2;
    bus.sample_valid = 1'b0;
    bus.arm          = 1'b0;
    bus.rst_trig     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample = 16'd0; bus.sample_valid = 1'b0; bus.ch_sel = 1'b0;
    bus.level = 8'd100; bus.hyst = 8'd0; bus.slope = 2'd1; bus.mode = 2'd0;
    bus.holdoff = 16'd0; bus.arm = 1'b0; bus.rst_trig = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL reset_status: got %b expected %b", st, 4'b0000); end
    tests_run++; if (bus.trig_ch !== 1'b0) begin tests_failed++; $display("FAIL reset_trig_ch: got %b expected %b", bus.trig_ch, 1'b0); end
    rst = 1'b0;
    tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL idle_no_arm: got %b expected %b", st, 4'b0000); end
  endtask

  task automatic test_rise_normal();
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL armed_after_arm: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd90, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd95, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL below_level_no_trig: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd105, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL rise_pulse: got %b expected %b", st, 4'b1100); end
    tests_run++; if (bus.trig_ch !== 1'b0) begin tests_failed++; $display("FAIL rise_trig_ch: got %b expected %b", bus.trig_ch, 1'b0); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1000) begin tests_failed++; $display("FAIL pulse_one_cycle: got %b expected %b", st, 4'b1000); end
    repeat (3) tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1000) begin tests_failed++; $display("FAIL trigger_sticky: got %b expected %b", st, 4'b1000); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL ack_rearm: got %b expected %b", st, 4'b0001); end
  endtask

  task automatic test_hysteresis();
    bus.hyst = 8'd10;
    tick(1'b1, 8'd95, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd101, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL hyst_inside_band: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd85, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL hyst_below_band: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd100, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL hyst_trig: got %b expected %b", st, 4'b1100); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    bus.hyst = 8'd0;
  endtask

  task automatic test_auto();
    bus.mode = 2'd1;
    for (int i = 0; i < 14; i++) tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL auto_before_top: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1110) begin tests_failed++; $display("FAIL auto_timeout: got %b expected %b", st, 4'b1110); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL auto_ack: got %b expected %b", st, 4'b0001); end
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
      tick(1'b0, 8'd50, 8'd0, 1'b0, 1'b0);
    end
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL auto_half_duty_early: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1110) begin tests_failed++; $display("FAIL auto_half_duty: got %b expected %b", st, 4'b1110); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    bus.mode = 2'd2;
    tick(1'b1, 8'd100, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL single_trig: got %b expected %b", st, 4'b1100); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL single_to_idle: got %b expected %b", st, 4'b0000); end
    tick(1'b1, 8'd80, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL single_ignore_idle: got %b expected %b", st, 4'b0000); end
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    tick(1'b1, 8'd80, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL single_rearm_trig: got %b expected %b", st, 4'b1100); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    bus.mode = 2'd0;
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_holdoff();
    bus.slope = 2'd2;
    bus.holdoff = 16'd4;
    tick(1'b1, 8'd80, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL fall_trig_either: got %b expected %b", st, 4'b1100); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL holdoff_entered: got %b expected %b", st, 4'b0000); end
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd80, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL holdoff_ignores: got %b expected %b", st, 4'b0000); end
    tick(1'b1, 8'd80, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL holdoff_done: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL post_holdoff_trig: got %b expected %b", st, 4'b1100); end
    bus.holdoff = 16'd0;
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    bus.slope = 2'd1;
    tick(1'b1, 8'd80, 8'd0, 1'b0, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL arm_ignored_armed: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b1);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL trig_over_ack: got %b expected %b", st, 4'b1100); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1000) begin tests_failed++; $display("FAIL ack_dropped_in_armed: got %b expected %b", st, 4'b1000); end
    bus.mode = 2'd1;
    tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd120, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL hit_with_timeout: got %b expected %b", st, 4'b1100); end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1000) begin tests_failed++; $display("FAIL pre_rst_triggered: got %b expected %b", st, 4'b1000); end
    rst = 1'b1;
    #1;
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL async_rst_immediate: got %b expected %b", st, 4'b0000); end
    #1;
    rst = 1'b0;
    bus.mode = 2'd0;
    tick(1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0000) begin tests_failed++; $display("FAIL idle_after_rst: got %b expected %b", st, 4'b0000); end
  endtask

  task automatic test_ch_change();
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    tick(1'b1, 8'd80, 8'd80, 1'b0, 1'b0);
    bus.ch_sel = 1'b1;
    tick(1'b1, 8'd120, 8'd120, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL no_trig_on_ch_switch: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd0, 8'd80, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL ch1_first_low: got %b expected %b", st, 4'b0001); end
    tick(1'b1, 8'd0, 8'd120, 1'b0, 1'b0);
    tests_run++; if (st !== 4'b1100) begin tests_failed++; $display("FAIL ch1_trig: got %b expected %b", st, 4'b1100); end
    tests_run++; if (bus.trig_ch !== 1'b1) begin tests_failed++; $display("FAIL trig_ch_latched: got %b expected %b", bus.trig_ch, 1'b1); end
    tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    tests_run++; if (st !== 4'b0001) begin tests_failed++; $display("FAIL ch1_ack: got %b expected %b", st, 4'b0001); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_rise_normal();
    test_hysteresis();
    test_auto();
    test_single();
    test_holdoff();
    test_back_to_back();
    test_async_reset();
    test_ch_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trig_ctrl_gen.md
Name: trig_ctrl_gen

Overview:
Parametrised next-generation oscilloscope trigger controller. It selects one of NCH sample channels and detects level crossings with programmable hysteresis, on rising, falling or either slope. It supports normal, auto and single-shot modes with an auto-trigger timeout and a post-trigger holdoff. It sits between the sampler/ADC front end and the capture-buffer/display controller, which acknowledges each trigger via rst_trig.

Parameters:
DW, 8, sample and level width in bits
NCH, 2, number of sample channels
CW, 1, channel-select width; must satisfy 2**CW >= NCH
AUTO_TOP, 15, valid samples without a crossing before an auto trigger fires
AW, 20, auto-counter width
HW, 16, holdoff-count width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
sample  in  NCH*DW  packed unsigned samples; channel k occupies bits [k*DW +: DW]
sample_valid  in  1  qualifies sample; all detection and counting advance only on valid cycles
ch_sel  in  CW  trigger source channel
level  in  DW  unsigned trigger level
hyst  in  DW  hysteresis band, unsigned
slope  in  2  0=falling, 1=rising, 2=either, 3=rising
mode  in  2  0=normal, 1=auto, 2=single, 3=normal
holdoff  in  HW  valid samples to ignore after acknowledge
arm  in  1  single-cycle pulse: leave IDLE
rst_trig  in  1  single-cycle pulse: trigger acknowledge from capture side
trigger  out  1  sticky trigger flag
trig_pulse  out  1  one-cycle strobe on the trigger event
trig_auto  out  1  1 when the current trigger came from timeout
trig_ch  out  CW  channel latched at the trigger event
armed  out  1  FSM is in ARMED

Behaviour:
- Reset values: trigger=0, trig_pulse=0, trig_auto=0, trig_ch=0, armed=0. FSM=IDLE; auto counter, holdoff counter, hysteresis flags and history-valid count all 0.
- Edge detector, evaluated on valid cycles for the selected channel:
  - lo_th = level-hyst, saturating at 0. hi_th = level+hyst, saturating at 2**DW-1.
  - below flag: set when s<lo_th; cleared on a rising hit.
  - above flag: set when s>hi_th; cleared on a falling hit.
  - rise_hit = below && s>=level. fall_hit = above && s<=level.
  - hyst=0 reproduces the plain crossing test: previous<level, current>=level.
  - At least 2 valid samples must have been seen since a ch_sel change or reset before any hit is accepted. A ch_sel change clears the flags and the history count.
- FSM states:
  - IDLE: on arm, go to ARMED.
  - ARMED: on hit, or auto timeout when mode=1, go to TRIGGERED. In that same transition: trigger=1, trig_pulse=1, trig_ch=ch_sel, trig_auto=timeout-only.
  - TRIGGERED: on rst_trig, clear trigger. If mode=2, go to IDLE. Otherwise go to HOLDOFF, or straight to ARMED if holdoff=0.
  - HOLDOFF: count valid samples; when the count reaches holdoff, go to ARMED.
- Latency: trigger and trig_pulse assert on the clock edge after the valid sample that completes the crossing.
- Auto counter:
  - Counts valid cycles in ARMED only; cleared on entry to ARMED and on any hit.
  - Timeout when count==AUTO_TOP-1 on a valid cycle.
  - A hit and a timeout in the same cycle give trig_auto=0.
- Simultaneous events and boundaries:
  - rst_trig in a cycle where ARMED would trigger: the trigger is taken; rst_trig is ignored, because it is only meaningful in TRIGGERED.
  - arm outside IDLE is ignored.
  - A mode change takes effect on the next state decision; no flush.
  - Edge detection keeps running in IDLE, HOLDOFF and TRIGGERED, so flags stay current, but hits are discarded.
  - ch_sel >= NCH selects channel 0.
  - rst asserted mid-operation returns every output and state to reset values immediately.

Decomposition:
- Package trig_pkg holds:
  - localparams for mode codes (MODE_NORM, MODE_AUTO, MODE_SINGLE)
  - slope codes (SLOPE_FALL, SLOPE_RISE, SLOPE_BOTH)
  - FSM state encoding (ST_IDLE, ST_ARMED, ST_TRIG, ST_HOLD)
- Sub-module trig_edge_det(DW): threshold saturation, below/above flags, history count, rise_hit/fall_hit.
- The top level holds the channel mux, FSM, auto counter, holdoff counter and output registers.

Test Plan:
1. Rising, normal, hyst=0, level=100. After arm, valid ch0 samples 90, 95, 105 -> trig_pulse one cycle after 105; trigger stays 1 until rst_trig; trig_auto=0; trig_ch=0.
2. Hysteresis, level=100, hyst=10. Samples 95, 101 -> no trigger because 95 is not below 90. Then 85, 100 -> trigger.
3. Auto mode, AUTO_TOP=15, constant sample 50, level=100 -> trigger with trig_auto=1 after the 15th valid sample in ARMED. Repeat the case with sample_valid at 50% duty -> the timeout still takes 15 valid samples.
4. Single mode -> one trigger; after rst_trig, FSM is in IDLE and further crossings are ignored until the next arm.
5. Normal mode, holdoff=4, either slope -> crossings during the 4 valid samples after rst_trig are ignored; the next crossing triggers.
6. Async rst mid-TRIGGERED -> trigger=0 and armed=0 immediately. Also: a ch_sel change from 0 to 1 -> no trigger before 2 valid ch1 samples.
